// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I data-memory responder.
//   - funct3 encodings for loads and stores (B, H, W, BU, HU)
//   - FSM state type for the responder's request/response sequencing
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data-memory responder.
// Ports:
//   we          : 1 = store, 0 = load
//   funct3      : RV32I load/store width code
//   lane        : byte address bits [1:0]
//   wdata       : right-aligned store data from the core
//   rword       : 32-bit word currently held at the addressed location
//   byte_en     : per-lane write enables (all zero for loads and errors)
//   wdata_lanes : store data replicated so every enabled lane sees its byte
//   rdata       : extended load result (zero for stores and errors)
//   err         : misaligned access or illegal funct3
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and half out of the stored word (little-endian).
  always_comb begin
    sel_byte = rword[7:0];
    case (lane)
      2'd0: sel_byte = rword[7:0];
      2'd1: sel_byte = rword[15:8];
      2'd2: sel_byte = rword[23:16];
      2'd3: sel_byte = rword[31:24];
      default: sel_byte = rword[7:0];
    endcase
    sel_half = lane[1] ? rword[31:16] : rword[15:0];
  end

  // Error detection: unsigned widths only exist for loads, halves need an
  // even address and words need a word-aligned address.
  always_comb begin
    err = 1'b0;
    case (funct3)
      F3_B:         err = 1'b0;
      F3_H:         err = lane[0];
      F3_W:         err = (lane != 2'b00);
      F3_BU, F3_HU: err = we || ((funct3 == F3_HU) && lane[0]);
      default:      err = 1'b1;
    endcase
  end

  // Store enables and load extension; an erroring access produces neither.
  // Store data is replicated across lanes so the enables alone select
  // where it lands.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    rdata       = 32'h0;
    if (!err) begin
      if (we) begin
        case (funct3)
          F3_B: begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{wdata[7:0]}};
          end
          F3_H: begin
            byte_en     = lane[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{wdata[15:0]}};
          end
          F3_W: begin
            byte_en     = 4'b1111;
            wdata_lanes = wdata;
          end
          default: byte_en = 4'b0000;
        endcase
      end else begin
        case (funct3)
          F3_B:    rdata = {{24{sel_byte[7]}}, sel_byte};
          F3_BU:   rdata = {24'h0, sel_byte};
          F3_H:    rdata = {{16{sel_half[15]}}, sel_half};
          F3_HU:   rdata = {16'h0, sel_half};
          F3_W:    rdata = rword;
          default: rdata = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// One request at a time: accept in IDLE, spend WAIT_CYCLES in BUSY, do the
// check and memory access in ACCESS, then hold the response in RESP until
// the core takes it.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_we, req_funct3, req_addr, req_wdata : request fields
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata, rsp_err  : load result (0 for stores/errors) and error flag
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  dmem_state_t       state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rword;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_lanes;
  logic [31:0]       align_rdata;
  logic              align_err;

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign rword     = mem[addr_q[ADDR_W-1:2]];

  dmem_lane_align u_align (
    .we          (we_q),
    .funct3      (funct3_q),
    .lane        (addr_q[1:0]),
    .wdata       (wdata_q),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata       (align_rdata),
    .err         (align_err)
  );

  // Sequencing FSM with the wait-state counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wait_cnt <= CNT_W'(WAIT_CYCLES);
            state    <= (WAIT_CYCLES == 0) ? ACCESS : BUSY;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_W'(1)) state <= ACCESS;
        end
        ACCESS: begin
          rsp_rdata <= align_rdata;
          rsp_err   <= align_err;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is never cleared; a reset in the access cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && (state == ACCESS)) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr_q[ADDR_W-1:2]][i*8 +: 8] <= wdata_lanes[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states
// and one with zero. Expected responses go into a scoreboard queue when the
// request is driven and are popped when the DUT presents its response.
module tb_dmem_responder;
  import riscv_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [9:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  exp_t scoreboard[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   acceptWait;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reset one instance; called and returns at a falling edge.
  task automatic doReset(input int d);
    rst[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("rst%0d_req_ready", d), 32'(req_ready[d]), 32'd0);
    checkOutput($sformatf("rst%0d_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
    checkOutput($sformatf("rst%0d_rsp_rdata", d), rsp_rdata[d], 32'h0);
    checkOutput($sformatf("rst%0d_rsp_err", d), 32'(rsp_err[d]), 32'd0);
    rst[d] = 1'b0;
  endtask

  // Drive one request to the accept edge; called and returns around edges:
  // starts at a falling edge, returns #1 after the accepting rising edge.
  task automatic sendRequest(input int d, input string tag, input logic we, input logic [2:0] f3,
                             input logic [9:0] addr, input logic [31:0] wdata, output int waits);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    waits = 0;
    while (!req_ready[d] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready[d]) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = 32'hX;
  endtask

  // Full transaction: push expectation, send, measure latency, optionally
  // hold off the response for 'hold' cycles, compare, finish the handshake.
  // Starts at a falling edge and returns at the falling edge after the
  // response handshake, which is the idle bubble cycle.
  task automatic applyStimulus(input int d, input string tag, input logic we, input logic [2:0] f3,
                               input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr, input int hold);
    exp_t e;
    int   lat;
    int   expLat;
    e.rdata = expRdata;
    e.err   = expErr;
    scoreboard.push_back(e);
    expLat = (d == 0) ? 4 : 2;
    sendRequest(d, tag, we, f3, addr, wdata, acceptWait);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid[d] && lat < 20);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    if (scoreboard.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = scoreboard.pop_front();
      for (int i = 0; i < hold; i++) begin
        checkOutput($sformatf("%s_hold%0d_valid", tag, i), 32'(rsp_valid[d]), 32'd1);
        checkOutput($sformatf("%s_hold%0d_rdata", tag, i), rsp_rdata[d], e.rdata);
        checkOutput($sformatf("%s_hold%0d_req_ready", tag, i), 32'(req_ready[d]), 32'd0);
        @(negedge clk);
      end
      checkOutput({tag, "_rdata"}, rsp_rdata[d], e.rdata);
      checkOutput({tag, "_err"}, 32'(rsp_err[d]), 32'(e.err));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle_valid"}, 32'(rsp_valid[d]), 32'd0);
    checkOutput({tag, "_idle_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    int w;
    int sawValid;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = F3_W;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    @(negedge clk);
    doReset(0);
    doReset(1);

    // Word store and load-back.
    applyStimulus(0, "sw_010", 1'b1, F3_W, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    applyStimulus(0, "lw_010", 1'b0, F3_W, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Byte/half extension.
    applyStimulus(0, "lb_013",  1'b0, F3_B,  10'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    applyStimulus(0, "lbu_013", 1'b0, F3_BU, 10'h013, 32'h0, 32'h000000DE, 1'b0, 0);
    applyStimulus(0, "lh_012",  1'b0, F3_H,  10'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    applyStimulus(0, "lhu_010", 1'b0, F3_HU, 10'h010, 32'h0, 32'h0000BEEF, 1'b0, 0);
    applyStimulus(0, "lb_010",  1'b0, F3_B,  10'h010, 32'h0, 32'hFFFFFFEF, 1'b0, 0);

    // Partial stores leave other lanes untouched.
    applyStimulus(0, "sb_011",   1'b1, F3_B, 10'h011, 32'h12345677, 32'h0, 1'b0, 0);
    applyStimulus(0, "lw_after_sb", 1'b0, F3_W, 10'h010, 32'h0, 32'hDEAD77EF, 1'b0, 0);
    applyStimulus(0, "sh_012",   1'b1, F3_H, 10'h012, 32'h0000A5A5, 32'h0, 1'b0, 0);
    applyStimulus(0, "lw_after_sh", 1'b0, F3_W, 10'h010, 32'h0, 32'hA5A577EF, 1'b0, 0);

    // Errors: misaligned and illegal accesses have no memory effect.
    applyStimulus(0, "sw_014",   1'b1, F3_W, 10'h014, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    applyStimulus(0, "lw_012_mis", 1'b0, F3_W, 10'h012, 32'h0, 32'h0, 1'b1, 0);
    applyStimulus(0, "sh_015_mis", 1'b1, F3_H, 10'h015, 32'h0000FFFF, 32'h0, 1'b1, 0);
    applyStimulus(0, "lw_014",   1'b0, F3_W, 10'h014, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    applyStimulus(0, "f3_011",   1'b0, 3'b011, 10'h010, 32'h0, 32'h0, 1'b1, 0);
    applyStimulus(0, "sbu_store", 1'b1, F3_BU, 10'h014, 32'h000000AA, 32'h0, 1'b1, 0);
    applyStimulus(0, "lw_014_again", 1'b0, F3_W, 10'h014, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    // Backpressure, then a back-to-back request right after the bubble.
    applyStimulus(0, "bp_lw", 1'b0, F3_W, 10'h010, 32'h0, 32'hA5A577EF, 1'b0, 5);
    applyStimulus(0, "b2b_lhu", 1'b0, F3_HU, 10'h012, 32'h0, 32'h0000A5A5, 1'b0, 0);
    checkOutput("b2b_accept_wait", 32'(acceptWait), 32'd0);

    // Reset during BUSY abandons the store.
    applyStimulus(0, "sw_020_pre", 1'b1, F3_W, 10'h020, 32'h0BADF00D, 32'h0, 1'b0, 0);
    sendRequest(0, "sw_020_abort", 1'b1, F3_W, 10'h020, 32'h11111111, w);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    sawValid = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[0]) sawValid = 1;
      @(negedge clk);
    end
    checkOutput("abort_no_rsp_valid", 32'(sawValid), 32'd0);
    applyStimulus(0, "lw_020", 1'b0, F3_W, 10'h020, 32'h0, 32'h0BADF00D, 1'b0, 0);

    // Zero wait-state instance: two-cycle latency.
    applyStimulus(1, "w0_sw_040", 1'b1, F3_W, 10'h040, 32'h13579BDF, 32'h0, 1'b0, 0);
    applyStimulus(1, "w0_lw_040", 1'b0, F3_W, 10'h040, 32'h0, 32'h13579BDF, 1'b0, 0);
    applyStimulus(1, "w0_lh_042", 1'b0, F3_H, 10'h042, 32'h0, 32'h00001357, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RISC-V core's load/store port. It serves one request at a time over a valid/ready request channel and a valid/ready response channel.
- Supports byte, half and word loads and stores selected by RV32I funct3, with sign/zero extension on loads.
- Inserts a programmable number of wait states so the core can later be exercised against non-zero-latency memory.
- Flags misaligned or illegal accesses instead of performing them.

Parameters:
- ADDR_W, 10, byte-address width; storage depth is 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 2, wait states between request acceptance and the memory access; 0 is legal.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts the response
- rsp_rdata  output  32  load result, extended; 0 for stores and for errors
- rsp_err  output  1  misaligned or illegal funct3; no memory effect

Behaviour:
- Reset: one clk, rst high. Effects: state=IDLE, req_ready=0 while rst is high, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not cleared.
- Reset mid-operation: the pending transaction is abandoned. If the store had not yet reached its access cycle, it is not performed.
- FSM state IDLE:
  - req_ready=1.
  - Handshake: req_valid&&req_ready. On handshake, latch we/funct3/addr/wdata and load counter with WAIT_CYCLES.
  - Next state is BUSY, or ACCESS if WAIT_CYCLES=0.
- FSM state BUSY:
  - req_ready=0.
  - Counter decrements each cycle. When the counter reaches 1, next state is ACCESS.
- FSM state ACCESS:
  - Single cycle. Perform the check and the memory access, and register rsp_rdata/rsp_err. Next state is RESP.
- FSM state RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake, next state is IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake (one bubble).
- Latency: a request accepted in cycle N gives rsp_valid in cycle N+WAIT_CYCLES+2.
- Word index: addr[ADDR_W-1:2]; the full address space maps to storage, with no out-of-range case. Byte lane: addr[1:0].
- Error conditions (rsp_err=1, rsp_rdata=0, no write):
  - funct3 of 011, 110 or 111.
  - Any store with funct3 100 or 101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
- Stores:
  - SB writes req_wdata[7:0] into lane addr[1:0].
  - SH writes req_wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - SW writes all 4 lanes.
  - Unselected lanes are unchanged.
- Loads:
  - Select the lane(s) by the same addressing as stores.
  - B and H sign-extend to 32 bits; BU and HU zero-extend; W returns the word.
- Little-endian: lane 0 is bits [7:0].
- Request inputs are ignored outside IDLE. The core must hold the request fields stable only on the handshake cycle.
- rsp_valid must not drop before rsp_ready. rsp_ready while rsp_valid=0 has no effect.

Decomposition:
- Shared package (riscv_pkg): funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU and an FSM state enum (IDLE, BUSY, ACCESS, RESP).
- One natural sub-module, dmem_lane_align. It is combinational and contains:
  - store byte-enable and lane-shifted write data;
  - load lane select and extension;
  - misalign/illegal detection.
- The FSM, counter and storage array stay in dmem_responder.

Test Plan:
1. Reset then SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid asserts exactly 4 cycles after each accept (WAIT_CYCLES=2).
2. Byte/half extension, after scenario 1:
   - LB 0x013 -> 0xFFFFFFDE.
   - LBU 0x013 -> 0x000000DE.
   - LH 0x012 -> 0xFFFFDEAD.
   - LHU 0x010 -> 0x0000BEEF.
3. Partial stores: SB 0x011 data 0x12345677, then LW 0x010 -> 0xDEAD77EF; SH 0x012 data 0x0000A5A5, then LW 0x010 -> 0xA5A577EF.
4. Errors:
   - LW 0x012 -> rsp_err=1, rdata=0.
   - SH 0x015 data 0xFFFF -> rsp_err=1, and a following LW 0x014 returns its prior value.
   - funct3=011 -> rsp_err=1.
5. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; raise rsp_ready -> IDLE next cycle, and a back-to-back request is accepted one cycle after the response handshake.
6. Reset mid-operation: accept SW 0x020 data 0x11111111, assert rst in the first BUSY cycle -> rsp_valid never asserts; a later LW 0x020 returns the pre-existing value. Rerun with WAIT_CYCLES=0 -> latency is 2 cycles.
